mem_wb_writeback: RTL and testbench

Writeback stage that consumes the 3-bit WB control bundle and data operands leaving the MEM/WB pipeline register. It selects the write-back value, commits it to a 32-entry general-purpose register file, and serves the decode stage's two read ports. It also keeps a retired-write counter and a sticky illegal-select flag for debug. It sits at the far end of the pipeline, closing the loop back to ID.

---
 rtl/mem_wb_writeback_pkg.sv | 24 ++
 rtl/mem_wb_writeback_if.sv | 38 +++
 rtl/mem_wb_writeback_gpr_array.sv | 71 +++++++
 rtl/mem_wb_writeback.sv | 90 +++++++++
 tb/tb_mem_wb_writeback.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_writeback_pkg.sv
// Shared definitions for the writeback stage: MemtoReg encodings, WB control
// bit positions and default widths.
package wb_pkg;

    localparam int WB_DATA_WIDTH   = 32;
    localparam int WB_ADDR_WIDTH   = 5;
    localparam int WB_CNT_WIDTH    = 32;

    localparam int WB_REGWRITE     = 2;
    localparam int WB_MEMTOREG_MSB = 1;
    localparam int WB_MEMTOREG_LSB = 0;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_MEM  = 2'b01,
        SEL_PC4  = 2'b10,
        SEL_RSVD = 2'b11
    } memtoreg_e;

    function automatic logic is_reserved_sel(input memtoreg_e sel);
        return (sel == SEL_RSVD);
    endfunction

endpackage

// File: rtl/mem_wb_writeback_if.sv
// MEM/WB-to-writeback bundle plus the ID-stage read ports and debug outputs.
// The master side drives pipeline operands and read indices; the slave is the writeback stage.
interface mem_wb_writeback_if
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) ();

    logic [2:0]              wb_ctrl;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic [DATA_WIDTH-1:0]   mem_read_data;
    logic [DATA_WIDTH-1:0]   pc_plus4;
    logic [ADDR_WIDTH-1:0]   write_reg;
    logic [ADDR_WIDTH-1:0]   read_reg1;
    logic [ADDR_WIDTH-1:0]   read_reg2;
    logic [DATA_WIDTH-1:0]   read_data1;
    logic [DATA_WIDTH-1:0]   read_data2;
    logic [DATA_WIDTH-1:0]   wb_write_data;
    logic                    wb_write_en;
    logic [WB_CNT_WIDTH-1:0] retired_writes;
    logic                    illegal_sel;

    modport master (
        output wb_ctrl, alu_result, mem_read_data, pc_plus4, write_reg,
        output read_reg1, read_reg2,
        input  read_data1, read_data2, wb_write_data, wb_write_en,
        input  retired_writes, illegal_sel
    );

    modport slave (
        input  wb_ctrl, alu_result, mem_read_data, pc_plus4, write_reg,
        input  read_reg1, read_reg2,
        output read_data1, read_data2, wb_write_data, wb_write_en,
        output retired_writes, illegal_sel
    );

endinterface

// File: rtl/mem_wb_writeback_gpr_array.sv
// 2-read/1-write general-purpose register array with r0 hardwired to zero.
// Optional same-cycle write-to-read forwarding under WB_BYPASS_EN.
module gpr_array #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr1_i,
    input  logic [ADDR_WIDTH-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // Next array contents: reset clears everything, r0 is never written.
    always_comb begin
        regs_d = regs_q;
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = {DATA_WIDTH{1'b0}};
            end
        end else if (we_i && (waddr_i != {ADDR_WIDTH{1'b0}})) begin
            regs_d[waddr_i] = wdata_i;
        end else begin
            regs_d = regs_q;
        end
    end

    // Array state register.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Read ports; index 0 reads as zero regardless of stored contents.
    always_comb begin
        rdata1_o = {DATA_WIDTH{1'b0}};
        rdata2_o = {DATA_WIDTH{1'b0}};
        if (raddr1_i != {ADDR_WIDTH{1'b0}}) begin
            rdata1_o = regs_q[raddr1_i];
        end else begin
            rdata1_o = {DATA_WIDTH{1'b0}};
        end
        if (raddr2_i != {ADDR_WIDTH{1'b0}}) begin
            rdata2_o = regs_q[raddr2_i];
        end else begin
            rdata2_o = {DATA_WIDTH{1'b0}};
        end
`ifdef WB_BYPASS_EN
        // we_i is already qualified by reset and a nonzero destination.
        if (we_i && (raddr1_i == waddr_i)) begin
            rdata1_o = wdata_i;
        end else begin
            rdata1_o = rdata1_o;
        end
        if (we_i && (raddr2_i == waddr_i)) begin
            rdata2_o = wdata_i;
        end else begin
            rdata2_o = rdata2_o;
        end
`endif
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// Writeback stage: selects the write-back value, commits to the GPR array,
// and tracks retired writes and illegal MemtoReg use. Optional macro: WB_BYPASS_EN.
module mem_wb_writeback
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
    input logic              clk,
    input logic              reset,
    mem_wb_writeback_if.slave wb
);

    logic                    regwrite_s;
    memtoreg_e               sel_s;
    logic [DATA_WIDTH-1:0]   wb_data_s;
    logic                    wb_en_s;
    logic                    illegal_hit_s;
    logic [WB_CNT_WIDTH-1:0] retired_q;
    logic [WB_CNT_WIDTH-1:0] retired_d;
    logic                    illegal_q;
    logic                    illegal_d;

    assign regwrite_s    = wb.wb_ctrl[WB_REGWRITE];
    assign sel_s         = memtoreg_e'(wb.wb_ctrl[WB_MEMTOREG_MSB:WB_MEMTOREG_LSB]);
    assign illegal_hit_s = regwrite_s & is_reserved_sel(sel_s);

    // Write-back source select; the reserved encoding yields zero.
    always_comb begin
        wb_data_s = {DATA_WIDTH{1'b0}};
        case (sel_s)
            SEL_ALU:  wb_data_s = wb.alu_result;
            SEL_MEM:  wb_data_s = wb.mem_read_data;
            SEL_PC4:  wb_data_s = wb.pc_plus4;
            SEL_RSVD: wb_data_s = {DATA_WIDTH{1'b0}};
            default:  wb_data_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    assign wb_en_s = regwrite_s & ~is_reserved_sel(sel_s)
                   & (wb.write_reg != {ADDR_WIDTH{1'b0}}) & reset;

    // Retired-write counter and sticky illegal flag next state; reset dominates.
    always_comb begin
        retired_d = retired_q;
        illegal_d = illegal_q;
        if (!reset) begin
            retired_d = {WB_CNT_WIDTH{1'b0}};
            illegal_d = 1'b0;
        end else begin
            if (wb_en_s) begin
                retired_d = retired_q + {{(WB_CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                retired_d = retired_q;
            end
            if (illegal_hit_s) begin
                illegal_d = 1'b1;
            end else begin
                illegal_d = illegal_q;
            end
        end
    end

    // Debug state registers.
    always_ff @(posedge clk) begin
        retired_q <= retired_d;
        illegal_q <= illegal_d;
    end

    gpr_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_gpr (
        .clk      (clk),
        .reset    (reset),
        .we_i     (wb_en_s),
        .waddr_i  (wb.write_reg),
        .wdata_i  (wb_data_s),
        .raddr1_i (wb.read_reg1),
        .raddr2_i (wb.read_reg2),
        .rdata1_o (wb.read_data1),
        .rdata2_o (wb.read_data2)
    );

    assign wb.wb_write_data  = wb_data_s;
    assign wb.wb_write_en    = wb_en_s;
    assign wb.retired_writes = retired_q;
    assign wb.illegal_sel    = illegal_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: directed table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_mem_wb_writeback;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    mem_wb_writeback_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    mem_wb_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rst;
        logic [2:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc4;
        logic [4:0]  wr;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] e_wd;
        logic        e_en;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_cnt;
        logic        e_ill;
    } vec_t;

    vec_t tbl [11];

    // Behavioural model state
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic        m_ill;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [2:0] ctrl, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc4, input logic [4:0] wr,
                         input logic [4:0] rr1, input logic [4:0] rr2);
        reset             = rst;
        bus.wb_ctrl       = ctrl;
        bus.alu_result    = alu;
        bus.mem_read_data = mem;
        bus.pc_plus4      = pc4;
        bus.write_reg     = wr;
        bus.read_reg1     = rr1;
        bus.read_reg2     = rr2;
    endtask

    function automatic logic [31:0] model_data(input logic [2:0] ctrl, input logic [31:0] alu,
                                               input logic [31:0] mem, input logic [31:0] pc4);
        logic [31:0] srcs [4];
        srcs[0] = alu;
        srcs[1] = mem;
        srcs[2] = pc4;
        srcs[3] = 32'h0;
        return srcs[ctrl[1:0]];
    endfunction

    function automatic logic model_en(input logic rst, input logic [2:0] ctrl, input logic [4:0] wr);
        return rst && ctrl[2] && (ctrl[1:0] != 2'b11) && (wr != 5'd0);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r, input logic en,
                                               input logic [4:0] wr, input logic [31:0] wd);
        if (r == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (en && (r == wr)) return wd;
`endif
        return m_regs[r];
    endfunction

    initial begin
        logic        r_rst;
        logic [2:0]  r_ctrl;
        logic [31:0] r_alu, r_mem, r_pc4, r_wd;
        logic [4:0]  r_wr, r_rr1, r_rr2;
        logic        r_en;

        vectors     = 0;
        miscompares = 0;

        tbl[0]  = '{1'b0, 3'b100, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd5, 5'd5, 5'd0,
                    32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0};
        tbl[1]  = '{1'b1, 3'b100, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5,
                    32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd1, 1'b0};
        tbl[2]  = '{1'b1, 3'b101, 32'h0, 32'h1234_5678, 32'h0, 5'd7, 5'd7, 5'd5,
                    32'h1234_5678, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 32'd2, 1'b0};
        tbl[3]  = '{1'b1, 3'b110, 32'h0, 32'h0, 32'h0000_0404, 5'd31, 5'd31, 5'd7,
                    32'h0000_0404, 1'b1, 32'h0000_0404, 32'h1234_5678, 32'd3, 1'b0};
        tbl[4]  = '{1'b1, 3'b100, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
                    32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 32'd3, 1'b0};
        tbl[5]  = '{1'b1, 3'b011, 32'h1111, 32'h2222, 32'h3333, 5'd6, 5'd6, 5'd5,
                    32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'd3, 1'b0};
        tbl[6]  = '{1'b1, 3'b111, 32'hAAAA, 32'h0, 32'h0, 5'd3, 5'd3, 5'd31,
                    32'h0, 1'b0, 32'h0, 32'h0000_0404, 32'd3, 1'b1};
        tbl[7]  = '{1'b1, 3'b000, 32'h55, 32'h0, 32'h0, 5'd5, 5'd5, 5'd3,
                    32'h55, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'd3, 1'b1};
        tbl[8]  = '{1'b1, 3'b100, 32'h77, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7,
                    32'h77, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'd3, 1'b1};
        tbl[9]  = '{1'b0, 3'b100, 32'h99, 32'h0, 32'h0, 5'd9, 5'd9, 5'd5,
                    32'h99, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0};
        tbl[10] = '{1'b1, 3'b010, 32'h0, 32'h0, 32'h80, 5'd9, 5'd9, 5'd31,
                    32'h80, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0};

        // Initial reset
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_cnt", bus.retired_writes, 32'd0);
        chk("reset_ill", {31'd0, bus.illegal_sel}, 32'd0);

        // Directed table
        for (int k = 0; k < 11; k++) begin
            drive(tbl[k].rst, tbl[k].ctrl, tbl[k].alu, tbl[k].mem, tbl[k].pc4,
                  tbl[k].wr, tbl[k].rr1, tbl[k].rr2);
            #2;
            chk($sformatf("tbl%0d_wd", k), bus.wb_write_data, tbl[k].e_wd);
            chk($sformatf("tbl%0d_en", k), {31'd0, bus.wb_write_en}, {31'd0, tbl[k].e_en});
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_rd1", k), bus.read_data1, tbl[k].e_rd1);
            chk($sformatf("tbl%0d_rd2", k), bus.read_data2, tbl[k].e_rd2);
            chk($sformatf("tbl%0d_cnt", k), bus.retired_writes, tbl[k].e_cnt);
            chk($sformatf("tbl%0d_ill", k), {31'd0, bus.illegal_sel}, {31'd0, tbl[k].e_ill});
            @(negedge clk);
        end

        // After the table's reset every index reads zero on both ports
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, i[4:0], 5'(31 - i));
            #1;
            chk($sformatf("zero_rd1_%0d", i), bus.read_data1, 32'h0);
            chk($sformatf("zero_rd2_%0d", i), bus.read_data2, 32'h0);
        end
        @(negedge clk);

        // Same-cycle write and read of r9
        drive(1'b1, 3'b100, 32'hCAFE_0001, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9);
        #2;
`ifdef WB_BYPASS_EN
        chk("r9_same_cycle", bus.read_data2, 32'hCAFE_0001);
`else
        chk("r9_same_cycle", bus.read_data2, 32'h0);
`endif
        chk("r9_same_ports", bus.read_data1, bus.read_data2);
        @(posedge clk);
        #1;
        chk("r9_after", bus.read_data2, 32'hCAFE_0001);
        chk("r9_cnt", bus.retired_writes, 32'd1);
        @(negedge clk);

        // Reset in the same cycle as a write discards the write
        drive(1'b0, 3'b100, 32'h0000_0012, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9);
        @(negedge clk);
        drive(1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
        #1;
        chk("r9_reset_wins", bus.read_data2, 32'h0);
        chk("r9_reset_cnt", bus.retired_writes, 32'd0);

        // Sticky illegal flag across idle cycles, r4 untouched
        drive(1'b1, 3'b111, 32'h4444, 32'h0, 32'h0, 5'd4, 5'd4, 5'd4);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0);
            @(negedge clk);
            chk($sformatf("sticky_ill_%0d", i), {31'd0, bus.illegal_sel}, 32'd1);
            chk($sformatf("sticky_r4_%0d", i), bus.read_data1, 32'h0);
        end

        // Randomized traffic against the model; first cycle forces reset
        for (int n = 0; n < 400; n++) begin
            r_rst  = (n == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            r_ctrl = 3'($urandom_range(0, 7));
            r_alu  = $urandom;
            r_mem  = $urandom;
            r_pc4  = $urandom;
            r_wr   = 5'($urandom_range(0, 31));
            r_rr1  = ($urandom_range(0, 3) == 0) ? r_wr : 5'($urandom_range(0, 31));
            r_rr2  = ($urandom_range(0, 3) == 0) ? r_wr : 5'($urandom_range(0, 31));
            r_wd   = model_data(r_ctrl, r_alu, r_mem, r_pc4);
            r_en   = model_en(r_rst, r_ctrl, r_wr);

            drive(r_rst, r_ctrl, r_alu, r_mem, r_pc4, r_wr, r_rr1, r_rr2);
            #2;
            chk("rnd_wd", bus.wb_write_data, r_wd);
            chk("rnd_en", {31'd0, bus.wb_write_en}, {31'd0, r_en});
            if (n > 0) begin
                chk("rnd_rd1", bus.read_data1, model_read(r_rr1, r_en, r_wr, r_wd));
                chk("rnd_rd2", bus.read_data2, model_read(r_rr2, r_en, r_wr, r_wd));
            end
            @(posedge clk);
            if (!r_rst) begin
                for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
                m_cnt = 32'd0;
                m_ill = 1'b0;
            end else begin
                if (r_en) begin
                    m_regs[r_wr] = r_wd;
                    m_cnt        = m_cnt + 32'd1;
                end
                if (r_ctrl[2] && (r_ctrl[1:0] == 2'b11)) m_ill = 1'b1;
            end
            #1;
            chk("rnd_cnt", bus.retired_writes, m_cnt);
            chk("rnd_ill", {31'd0, bus.illegal_sel}, {31'd0, m_ill});
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
